// File: rtl/spi_fetch_arbiter.sv
// Shares one SPI byte engine between the video and audio fetch paths: arbitrates,
// then runs command byte, header hunt and fixed-length payload streaming for the grantee.
module spi_fetch_arbiter #(
    parameter logic [7:0] VIDEO_CMD = 8'hFA,
    parameter logic [7:0] AUDIO_CMD = 8'hAA,
    parameter logic [7:0] VIDEO_HDR = 8'h5A,
    parameter logic [7:0] AUDIO_HDR = 8'hA5,
    parameter int         VIDEO_LEN = 9600,
    parameter int         AUDIO_LEN = 1024,
    parameter int         HUNT_MAX  = 255,
    parameter int         LEN_W     = 14
) (
    input  logic       CLK_50,
    input  logic       reset,
    input  logic       vid_req,
    input  logic       aud_req,
    input  logic       aud_urgent,
    output logic       vid_grant,
    output logic       aud_grant,
    output logic [7:0] byte_data,
    output logic       vid_byte_valid,
    output logic       aud_byte_valid,
    output logic       txn_done,
    output logic       txn_error,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic       spi_done,
    input  logic [7:0] spi_rx,
    output logic       spi_cs_n
);

    typedef enum logic [2:0] {IDLE, SEND_CMD, HUNT, STREAM, FINISH} state_t;

    localparam logic [7:0]       HUNT_LAST = 8'(HUNT_MAX - 1);
    localparam logic [LEN_W-1:0] VID_LAST  = LEN_W'(VIDEO_LEN - 1);
    localparam logic [LEN_W-1:0] AUD_LAST  = LEN_W'(AUDIO_LEN - 1);

    state_t           state, state_nxt;
    logic             sel_aud, sel_aud_nxt;
    logic             last_aud, last_aud_nxt;
    logic             busy, busy_nxt;
    logic [7:0]       hunt_cnt, hunt_cnt_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             vid_grant_nxt, aud_grant_nxt;
    logic             vid_byte_valid_nxt, aud_byte_valid_nxt;
    logic             txn_done_nxt, txn_error_nxt, spi_start_nxt, spi_cs_n_nxt;
    logic [7:0]       byte_data_nxt, spi_tx_nxt;
    logic             close_txn, issue_slot;

    logic [7:0]       hdr;
    logic [LEN_W-1:0] last_idx;
    logic             pick_aud;
    logic             done_seen;

    assign hdr       = sel_aud ? AUDIO_HDR : VIDEO_HDR;
    assign last_idx  = sel_aud ? AUD_LAST : VID_LAST;
    // Urgent audio wins outright; otherwise a tie goes to the side not served last.
    assign pick_aud  = aud_req & (aud_urgent | ~vid_req | ~last_aud);
    assign done_seen = spi_done & busy;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_nxt          = state;
        sel_aud_nxt        = sel_aud;
        last_aud_nxt       = last_aud;
        busy_nxt           = busy & ~spi_done;
        hunt_cnt_nxt       = hunt_cnt;
        cnt_nxt            = cnt;
        vid_grant_nxt      = vid_grant;
        aud_grant_nxt      = aud_grant;
        byte_data_nxt      = byte_data;
        spi_tx_nxt         = spi_tx;
        spi_cs_n_nxt       = spi_cs_n;
        vid_byte_valid_nxt = 1'b0;
        aud_byte_valid_nxt = 1'b0;
        txn_done_nxt       = 1'b0;
        txn_error_nxt      = 1'b0;
        spi_start_nxt      = 1'b0;
        close_txn          = 1'b0;
        issue_slot         = 1'b0;

        case (state)
            IDLE: begin
                spi_cs_n_nxt = 1'b1;
                if (vid_req || aud_req) begin
                    state_nxt     = SEND_CMD;
                    sel_aud_nxt   = pick_aud;
                    vid_grant_nxt = ~pick_aud;
                    aud_grant_nxt = pick_aud;
                    spi_cs_n_nxt  = 1'b0;
                    spi_start_nxt = 1'b1;
                    spi_tx_nxt    = pick_aud ? AUDIO_CMD : VIDEO_CMD;
                    busy_nxt      = 1'b1;
                    hunt_cnt_nxt  = 8'd0;
                    cnt_nxt       = '0;
                end
            end
            SEND_CMD: begin
                if (done_seen) begin
                    state_nxt  = HUNT;
                    issue_slot = 1'b1;
                end
            end
            HUNT: begin
                if (done_seen) begin
                    if (spi_rx == hdr) begin
                        state_nxt  = STREAM;
                        cnt_nxt    = '0;
                        issue_slot = 1'b1;
                    end else begin
                        hunt_cnt_nxt = hunt_cnt + 8'd1;
                        if (hunt_cnt == HUNT_LAST) begin
                            txn_error_nxt = 1'b1;
                            close_txn     = 1'b1;
                        end else begin
                            issue_slot = 1'b1;
                        end
                    end
                end
            end
            STREAM: begin
                if (done_seen) begin
                    byte_data_nxt      = spi_rx;
                    vid_byte_valid_nxt = ~sel_aud;
                    aud_byte_valid_nxt = sel_aud;
                    // Count stops at the last index, so it can never wrap.
                    if (cnt == last_idx) begin
                        txn_done_nxt = 1'b1;
                        close_txn    = 1'b1;
                    end else begin
                        cnt_nxt    = cnt + LEN_W'(1);
                        issue_slot = 1'b1;
                    end
                end
            end
            FINISH: begin
                last_aud_nxt = sel_aud;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (issue_slot) begin
            spi_start_nxt = 1'b1;
            spi_tx_nxt    = 8'h00;
            busy_nxt      = 1'b1;
        end
        if (close_txn) begin
            state_nxt     = FINISH;
            spi_cs_n_nxt  = 1'b1;
            vid_grant_nxt = 1'b0;
            aud_grant_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sel_aud        <= 1'b0;
            last_aud       <= 1'b1;
            busy           <= 1'b0;
            hunt_cnt       <= 8'd0;
            cnt            <= '0;
            vid_grant      <= 1'b0;
            aud_grant      <= 1'b0;
            byte_data      <= 8'h00;
            vid_byte_valid <= 1'b0;
            aud_byte_valid <= 1'b0;
            txn_done       <= 1'b0;
            txn_error      <= 1'b0;
            spi_start      <= 1'b0;
            spi_tx         <= 8'h00;
            spi_cs_n       <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state          <= state_nxt;
            sel_aud        <= sel_aud_nxt;
            last_aud       <= last_aud_nxt;
            busy           <= busy_nxt;
            hunt_cnt       <= hunt_cnt_nxt;
            cnt            <= cnt_nxt;
            vid_grant      <= vid_grant_nxt;
            aud_grant      <= aud_grant_nxt;
            byte_data      <= byte_data_nxt;
            vid_byte_valid <= vid_byte_valid_nxt;
            aud_byte_valid <= aud_byte_valid_nxt;
            txn_done       <= txn_done_nxt;
            txn_error      <= txn_error_nxt;
            spi_start      <= spi_start_nxt;
            spi_tx         <= spi_tx_nxt;
            spi_cs_n       <= spi_cs_n_nxt;
        end
    end

endmodule
